// File: rtl/pipeline_stall_controller.sv
// -----------------------------------------------------------------------------
// pipeline_stall_controller
//
// Consumer side of the hazard detector. Turns hazard vectors, stall requests,
// the EX-stage flush request and the I/D-cache ready handshakes into pipeline
// register enables, bubble/flush controls and forwarding mux selects.
// It also tracks a wrong-path fetch that is still in flight when a flush lands
// during an I-cache miss, and keeps saturating stall/flush perf counters.
//
// Control outputs are combinational (same cycle as the inputs). Only the
// fetch-kill flag and the two counters are registered.
//
// Ports
//   clk               in   core clock, state updates on posedge
//   reset_n           in   asynchronous active-low reset
//   hazard_signal_if  in   [2:0] {wb,mem,ex} rs hazards for JPR/JRL in IF
//   hazard_signal_id  in   {rt_wb,rt_mem,rt_ex,rs_wb,rs_mem,rs_ex} in ID
//   stall             in   load-use stall request
//   stall_pc          in   JPR/JRL in IF waits for its rs value
//   flush_req         in   EX resolved a taken/mispredicted control transfer
//   i_mem_ready       in   I-cache delivers the fetched word this cycle
//   d_mem_ready       in   D-cache access in MEM complete
//   pc_write .. memwb_bubble  out  pipeline register enables / bubbles
//   fwd_rs_sel, fwd_rt_sel, fwd_jr_sel  out  0 regfile, 1 EX, 2 MEM, 3 WB
//   stall_cycles      out  cycles with pc_write=0, saturating
//   flush_count       out  accepted flushes, saturating
// -----------------------------------------------------------------------------
module pipeline_stall_controller #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [5:0]       hazard_signal_if,
   input  logic [5:0]       hazard_signal_id,
   input  logic             stall,
   input  logic             stall_pc,
   input  logic             flush_req,
   input  logic             i_mem_ready,
   input  logic             d_mem_ready,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_write,
   output logic             idex_bubble,
   output logic             exmem_write,
   output logic             memwb_bubble,
   output logic [1:0]       fwd_rs_sel,
   output logic [1:0]       fwd_rt_sel,
   output logic [1:0]       fwd_jr_sel,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   // Which priority row is active this cycle (first match wins).
   typedef enum logic [2:0] {
      ROW_RESET    = 3'd0,
      ROW_FREEZE   = 3'd1,
      ROW_FLUSH    = 3'd2,
      ROW_STALL    = 3'd3,
      ROW_KILL     = 3'd4,
      ROW_IMISS    = 3'd5,
      ROW_STALL_PC = 3'd6,
      ROW_RUN      = 3'd7
   } row_t;

   row_t             row_s;
   logic             fetch_kill_r;
   logic             fetch_kill_s;
   logic [CNT_W-1:0] stall_cycles_r;
   logic [CNT_W-1:0] stall_cycles_s;
   logic [CNT_W-1:0] flush_count_r;
   logic [CNT_W-1:0] flush_count_s;
   logic             unused_if_bits_s;

   // Upper IF hazard bits carry no information for the jump-register path.
   assign unused_if_bits_s = ^hazard_signal_if[5:3];

   // Priority select among EX > MEM > WB hazards for one operand.
   function automatic logic [1:0] fwd_sel(input logic [2:0] haz);
      logic [1:0] sel;
      if (haz[0]) begin
         sel = 2'd1;
      end else if (haz[1]) begin
         sel = 2'd2;
      end else if (haz[2]) begin
         sel = 2'd3;
      end else begin
         sel = 2'd0;
      end
      return sel;
   endfunction

   // Saturating increment: counters stick at all-ones.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
      logic [CNT_W-1:0] res;
      if (val == {CNT_W{1'b1}}) begin
         res = val;
      end else begin
         res = val + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      return res;
   endfunction

   // Fetch-kill flag and perf counter registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fetch_kill_r   <= 1'b0;
         stall_cycles_r <= {CNT_W{1'b0}};
         flush_count_r  <= {CNT_W{1'b0}};
      end else begin
         fetch_kill_r   <= fetch_kill_s;
         stall_cycles_r <= stall_cycles_s;
         flush_count_r  <= flush_count_s;
      end
   end

   // Priority decode of the current cycle's event.
   always_comb begin
      row_s = ROW_RUN;
      if (!reset_n) begin
         row_s = ROW_RESET;
      end else if (!d_mem_ready) begin
         // Flush is deliberately ignored here: ID/EX is frozen and the
         // datapath keeps asserting flush_req until it can be taken.
         row_s = ROW_FREEZE;
      end else if (flush_req) begin
         row_s = ROW_FLUSH;
      end else if (stall) begin
         row_s = ROW_STALL;
      end else if (fetch_kill_r && i_mem_ready) begin
         row_s = ROW_KILL;
      end else if (!i_mem_ready) begin
         row_s = ROW_IMISS;
      end else if (stall_pc) begin
         row_s = ROW_STALL_PC;
      end else begin
         row_s = ROW_RUN;
      end
   end

   // Pipeline enables, bubbles and forwarding selects.
   always_comb begin
      pc_write     = 1'b1;
      ifid_write   = 1'b1;
      ifid_flush   = 1'b0;
      idex_write   = 1'b1;
      idex_bubble  = 1'b0;
      exmem_write  = 1'b1;
      memwb_bubble = 1'b0;
      case (row_s)
         ROW_RESET: begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            ifid_flush   = 1'b1;
            idex_write   = 1'b0;
            idex_bubble  = 1'b1;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
         end
         ROW_FREEZE: begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
         end
         ROW_FLUSH: begin
            pc_write    = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
         end
         ROW_STALL: begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
         end
         ROW_KILL: begin
            // PC already holds the flush target; drop the stale word.
            pc_write   = 1'b0;
            ifid_flush = 1'b1;
         end
         ROW_IMISS: begin
            pc_write   = 1'b0;
            ifid_flush = 1'b1;
         end
         ROW_STALL_PC: begin
            pc_write   = 1'b0;
            ifid_flush = 1'b1;
         end
         ROW_RUN: begin
            pc_write = 1'b1;
         end
         default: begin
            pc_write = 1'b1;
         end
      endcase

      if (reset_n) begin
         fwd_rs_sel = fwd_sel(hazard_signal_id[2:0]);
         fwd_rt_sel = fwd_sel(hazard_signal_id[5:3]);
         fwd_jr_sel = fwd_sel(hazard_signal_if[2:0]);
      end else begin
         fwd_rs_sel = 2'd0;
         fwd_rt_sel = 2'd0;
         fwd_jr_sel = 2'd0;
      end
   end

   // Next state of the wrong-path fetch flag and the perf counters.
   always_comb begin
      fetch_kill_s   = fetch_kill_r;
      stall_cycles_s = stall_cycles_r;
      flush_count_s  = flush_count_r;
      case (row_s)
         ROW_FLUSH: begin
            // A fetch still outstanding at flush time is for the old path.
            fetch_kill_s  = !i_mem_ready;
            flush_count_s = sat_inc(flush_count_r);
         end
         ROW_KILL: begin
            fetch_kill_s = 1'b0;
         end
         default: begin
            fetch_kill_s = fetch_kill_r;
         end
      endcase
      if (!pc_write) begin
         stall_cycles_s = sat_inc(stall_cycles_r);
      end else begin
         stall_cycles_s = stall_cycles_r;
      end
   end

   assign stall_cycles = stall_cycles_r;
   assign flush_count  = flush_count_r;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// -----------------------------------------------------------------------------
// Testbench for pipeline_stall_controller. A table of {inputs, expected
// outputs} vectors plus hand-written multi-cycle sequences. Expected control
// words go into a scoreboard queue when stimulus is driven and are popped and
// compared when the outputs are sampled on the falling edge. A small counter
// model tracks stall_cycles/flush_count for a 16-bit and a 2-bit instance.
// -----------------------------------------------------------------------------
module tb_pipeline_stall_controller;

   typedef struct {
      logic [5:0]  hif;
      logic [5:0]  hid;
      logic        st;
      logic        spc;
      logic        fr;
      logic        imr;
      logic        dmr;
      logic [12:0] exp;
   } vec_t;

   // Control word packing: {pc_write, ifid_write, ifid_flush, idex_write,
   // idex_bubble, exmem_write, memwb_bubble}
   localparam logic [6:0] C_RUN    = 7'b1101010;
   localparam logic [6:0] C_STALL  = 7'b0001110;
   localparam logic [6:0] C_IFLUSH = 7'b0111010;
   localparam logic [6:0] C_FREEZE = 7'b0000001;
   localparam logic [6:0] C_FLUSH  = 7'b1111110;
   localparam logic [6:0] C_RESET  = 7'b0010101;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [5:0] hazard_signal_if, hazard_signal_id;
   logic       stall, stall_pc, flush_req, i_mem_ready, d_mem_ready;

   logic        pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
   logic        exmem_write, memwb_bubble;
   logic [1:0]  fwd_rs_sel, fwd_rt_sel, fwd_jr_sel;
   logic [15:0] stall_cycles, flush_count;

   logic        pc_write2, ifid_write2, ifid_flush2, idex_write2, idex_bubble2;
   logic        exmem_write2, memwb_bubble2;
   logic [1:0]  fwd_rs_sel2, fwd_rt_sel2, fwd_jr_sel2;
   logic [1:0]  stall_cycles2, flush_count2;

   logic [12:0] obs;
   assign obs = {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
                 exmem_write, memwb_bubble, fwd_rs_sel, fwd_rt_sel, fwd_jr_sel};

   int errors = 0;
   int checks = 0;

   logic [12:0] sb_q[$];
   string       nm_q[$];
   logic [15:0] exp_sc, exp_fc;
   logic [1:0]  exp_sc2, exp_fc2;
   vec_t        tbl[16];
   vec_t        v;

   always #5 clk = ~clk;

   pipeline_stall_controller #(.CNT_W(16)) dut (
      .clk(clk), .reset_n(reset_n),
      .hazard_signal_if(hazard_signal_if), .hazard_signal_id(hazard_signal_id),
      .stall(stall), .stall_pc(stall_pc), .flush_req(flush_req),
      .i_mem_ready(i_mem_ready), .d_mem_ready(d_mem_ready),
      .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .idex_write(idex_write), .idex_bubble(idex_bubble),
      .exmem_write(exmem_write), .memwb_bubble(memwb_bubble),
      .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel), .fwd_jr_sel(fwd_jr_sel),
      .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   pipeline_stall_controller #(.CNT_W(2)) dut2 (
      .clk(clk), .reset_n(reset_n),
      .hazard_signal_if(hazard_signal_if), .hazard_signal_id(hazard_signal_id),
      .stall(stall), .stall_pc(stall_pc), .flush_req(flush_req),
      .i_mem_ready(i_mem_ready), .d_mem_ready(d_mem_ready),
      .pc_write(pc_write2), .ifid_write(ifid_write2), .ifid_flush(ifid_flush2),
      .idex_write(idex_write2), .idex_bubble(idex_bubble2),
      .exmem_write(exmem_write2), .memwb_bubble(memwb_bubble2),
      .fwd_rs_sel(fwd_rs_sel2), .fwd_rt_sel(fwd_rt_sel2), .fwd_jr_sel(fwd_jr_sel2),
      .stall_cycles(stall_cycles2), .flush_count(flush_count2)
   );

   function automatic vec_t mk(input logic [5:0] hif, input logic [5:0] hid,
                               input logic st, input logic spc, input logic fr,
                               input logic imr, input logic dmr,
                               input logic [6:0] ctrl, input logic [1:0] rs,
                               input logic [1:0] rt, input logic [1:0] jr);
      vec_t r;
      r.hif = hif; r.hid = hid; r.st = st; r.spc = spc; r.fr = fr;
      r.imr = imr; r.dmr = dmr;
      r.exp = {ctrl, rs, rt, jr};
      return r;
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // One clock cycle: drive, push expectation, sample on negedge, update model.
   task automatic step(input vec_t sv, input string nm);
      logic [12:0] e;
      string       en;
      @(posedge clk);
      #1;
      reset_n          = 1'b1;
      hazard_signal_if = sv.hif;
      hazard_signal_id = sv.hid;
      stall            = sv.st;
      stall_pc         = sv.spc;
      flush_req        = sv.fr;
      i_mem_ready      = sv.imr;
      d_mem_ready      = sv.dmr;
      sb_q.push_back(sv.exp);
      nm_q.push_back(nm);
      @(negedge clk);
      chk({nm, "/stall_cycles"}, stall_cycles, exp_sc);
      chk({nm, "/flush_count"}, flush_count, exp_fc);
      chk({nm, "/stall_cycles_w2"}, {14'd0, stall_cycles2}, {14'd0, exp_sc2});
      chk({nm, "/flush_count_w2"}, {14'd0, flush_count2}, {14'd0, exp_fc2});
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: scoreboard empty, got 0x%0h", nm, obs);
      end else begin
         e  = sb_q.pop_front();
         en = nm_q.pop_front();
         chk({en, "/ctrl"}, {3'd0, obs}, {3'd0, e});
      end
      // Counter model for the coming posedge.
      if (!sv.exp[12]) begin
         if (exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
         if (exp_sc2 != 2'd3) exp_sc2 = exp_sc2 + 2'd1;
      end
      if (sv.dmr && sv.fr) begin
         if (exp_fc != 16'hFFFF) exp_fc = exp_fc + 16'd1;
         if (exp_fc2 != 2'd3) exp_fc2 = exp_fc2 + 2'd1;
      end
   endtask

   // Assert reset asynchronously and check the reset-state outputs at once.
   task automatic do_reset(input string nm);
      reset_n = 1'b0;
      #1;
      chk({nm, "/ctrl"}, {3'd0, obs}, {3'd0, C_RESET, 6'd0});
      chk({nm, "/stall_cycles"}, stall_cycles, 16'd0);
      chk({nm, "/flush_count"}, flush_count, 16'd0);
      chk({nm, "/stall_cycles_w2"}, {14'd0, stall_cycles2}, 16'd0);
      exp_sc = 16'd0; exp_fc = 16'd0; exp_sc2 = 2'd0; exp_fc2 = 2'd0;
   endtask

   initial begin
      tbl[0]  = mk(6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, C_RUN,    2'd0, 2'd0, 2'd0);
      tbl[1]  = mk(6'b000000, 6'b000110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, C_RUN,    2'd2, 2'd0, 2'd0);
      tbl[2]  = mk(6'b000000, 6'b100000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, C_RUN,    2'd0, 2'd3, 2'd0);
      tbl[3]  = mk(6'b000000, 6'b111111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, C_RUN,    2'd1, 2'd1, 2'd0);
      tbl[4]  = mk(6'b000000, 6'b010100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, C_RUN,    2'd3, 2'd2, 2'd0);
      tbl[5]  = mk(6'b111110, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, C_RUN,    2'd0, 2'd0, 2'd2);
      tbl[6]  = mk(6'b000100, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, C_RUN,    2'd0, 2'd0, 2'd3);
      tbl[7]  = mk(6'b111000, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, C_RUN,    2'd0, 2'd0, 2'd0);
      tbl[8]  = mk(6'b000000, 6'b000000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, C_STALL,  2'd0, 2'd0, 2'd0);
      tbl[9]  = mk(6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_IFLUSH, 2'd0, 2'd0, 2'd0);
      tbl[10] = mk(6'b000000, 6'b000000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, C_IFLUSH, 2'd0, 2'd0, 2'd0);
      tbl[11] = mk(6'b000000, 6'b000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, C_STALL,  2'd0, 2'd0, 2'd0);
      tbl[12] = mk(6'b000000, 6'b000001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_FREEZE, 2'd1, 2'd0, 2'd0);
      tbl[13] = mk(6'b000000, 6'b000000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, C_FREEZE, 2'd0, 2'd0, 2'd0);
      tbl[14] = mk(6'b000000, 6'b000000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, C_FLUSH,  2'd0, 2'd0, 2'd0);
      tbl[15] = mk(6'b000000, 6'b000000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, C_FLUSH,  2'd0, 2'd0, 2'd0);

      // Power-on reset with every input active: selects must stay 0.
      hazard_signal_if = 6'b111111; hazard_signal_id = 6'b111111;
      stall = 1'b1; stall_pc = 1'b1; flush_req = 1'b1;
      i_mem_ready = 1'b0; d_mem_ready = 1'b1;
      #2;
      do_reset("reset");

      // Single-cycle table vectors.
      for (int i = 0; i < 16; i++) begin
         step(tbl[i], $sformatf("vec%0d", i));
      end

      // Freeze holds a flush for four cycles, then it is accepted.
      for (int i = 0; i < 4; i++) begin
         step(mk(6'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, C_FREEZE, 2'd0, 2'd0, 2'd0),
              $sformatf("freeze%0d", i));
      end
      step(mk(6'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, C_FLUSH, 2'd0, 2'd0, 2'd0), "freeze_flush");
      step(tbl[0], "freeze_after");

      // Flush during an I-miss; the word arrives three cycles later.
      step(mk(6'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, C_FLUSH,  2'd0, 2'd0, 2'd0), "kill_flush");
      step(mk(6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_IFLUSH, 2'd0, 2'd0, 2'd0), "kill_miss1");
      step(mk(6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_IFLUSH, 2'd0, 2'd0, 2'd0), "kill_miss2");
      step(mk(6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, C_IFLUSH, 2'd0, 2'd0, 2'd0), "kill_deliver");
      step(tbl[0], "kill_resume");

      // Fetch-kill survives a D-cache freeze.
      step(mk(6'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, C_FLUSH,  2'd0, 2'd0, 2'd0), "hold_flush");
      step(mk(6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_FREEZE, 2'd0, 2'd0, 2'd0), "hold_freeze");
      step(mk(6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, C_IFLUSH, 2'd0, 2'd0, 2'd0), "hold_deliver");
      step(tbl[0], "hold_resume");

      // Reset in the middle of a freeze with fetch-kill set clears it.
      step(mk(6'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, C_FLUSH,  2'd0, 2'd0, 2'd0), "rst_flush");
      step(mk(6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_FREEZE, 2'd0, 2'd0, 2'd0), "rst_freeze");
      #2;
      do_reset("midreset");
      step(tbl[0], "rst_resume");

      // Five stall cycles saturate the 2-bit counter at 3.
      for (int i = 0; i < 5; i++) begin
         step(tbl[8], $sformatf("sat%0d", i));
      end
      step(tbl[0], "sat_end");
      chk("sat_w2", {14'd0, stall_cycles2}, 16'd3);
      chk("sat_w16", stall_cycles, 16'd5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
